flow_led_ctrl: RTL and testbench

Parametrised running-light controller driving NUM_LED LEDs from a single prescaled step tick. It supports four patterns: rotate left, rotate right, ping-pong and blink-all. Step speed is selectable at run time. It replaces the fixed four-instance LED top: the board top instantiates one flow_led_ctrl and wires LED_out straight to pins.

---
 rtl/flow_led_ctrl.sv | 100 ++++++++++
 tb/tb_flow_led_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/flow_led_ctrl.sv
// Running-light controller: one prescaled step tick drives rotate-left, rotate-right,
// ping-pong or blink-all patterns across NUM_LED outputs.
module flow_led_ctrl #(
    parameter int NUM_LED     = 4,
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               En,
    input  logic [1:0]         Mode,
    input  logic [1:0]         Speed,
    output logic [NUM_LED-1:0] LED_out,
    output logic               Step_Tick
);
    localparam int CNT_W = $clog2(STEP_CYCLES);

    localparam logic [1:0] MODE_ROL   = 2'b00;
    localparam logic [1:0] MODE_ROR   = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    localparam logic [31:0]        STEP_U  = 32'(STEP_CYCLES);
    localparam logic [NUM_LED-1:0] LSB_ONE = NUM_LED'(1);
    localparam logic [NUM_LED-1:0] MSB_ONE = {1'b1, {(NUM_LED-1){1'b0}}};

    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_spd;
    logic [1:0]         r_mode_q;
    logic               r_dir;      // 0 = up (toward MSB), 1 = down
    logic [1:0]         w_spd;
    logic [31:0]        w_last;
    logic               w_at_last;
    logic               w_reload;
    logic [NUM_LED-1:0] w_init;
    logic [NUM_LED-1:0] w_next;

    // Speed is only picked up at the start of a step so a change never shortens it.
    assign w_spd     = (r_cnt == '0) ? Speed : r_spd;
    assign w_last    = (STEP_U >> w_spd) - 32'd1;
    assign w_at_last = ({{(32-CNT_W){1'b0}}, r_cnt} == w_last);
    assign w_reload  = (Mode != r_mode_q);

    always_comb begin
        w_init = LSB_ONE;
        case (Mode)
            MODE_ROR:   w_init = MSB_ONE;
            MODE_BLINK: w_init = '0;
            default:    w_init = LSB_ONE;
        endcase
    end

    always_comb begin
        w_next = LED_out;
        case (r_mode_q)
            MODE_ROL:  w_next = {LED_out[NUM_LED-2:0], LED_out[NUM_LED-1]};
            MODE_ROR:  w_next = {LED_out[0], LED_out[NUM_LED-1:1]};
            MODE_PING: w_next = r_dir ? (LED_out >> 1) : (LED_out << 1);
            default:   w_next = ~LED_out;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt     <= '0;
            r_spd     <= 2'b00;
            r_mode_q  <= MODE_ROL;
            r_dir     <= 1'b0;
            LED_out   <= LSB_ONE;
            Step_Tick <= 1'b0;
        end else begin
            r_mode_q <= Mode;
            r_spd    <= w_spd;
            if (w_reload) begin
                // Reload beats a coincident step: re-seed, no advance, no tick.
                r_cnt     <= '0;
                r_dir     <= 1'b0;
                LED_out   <= w_init;
                Step_Tick <= 1'b0;
            end else if (En) begin
                if (w_at_last) begin
                    r_cnt     <= '0;
                    LED_out   <= w_next;
                    Step_Tick <= 1'b1;
                    if (r_mode_q == MODE_PING) begin
                        if (w_next[NUM_LED-1])
                            r_dir <= 1'b1;
                        else if (w_next[0])
                            r_dir <= 1'b0;
                    end
                end else begin
                    r_cnt     <= r_cnt + 1'b1;
                    Step_Tick <= 1'b0;
                end
            end else begin
                Step_Tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Bench for flow_led_ctrl: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a position/sequence-index model.
module tb_flow_led_ctrl;
    localparam int N    = 4;
    localparam int STEP = 8;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         En = 1'b1;
    logic [1:0]   Mode = 2'b00;
    logic [1:0]   Speed = 2'b00;
    logic [N-1:0] LED_out;
    logic         Step_Tick;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    flow_led_ctrl #(.NUM_LED(N), .STEP_CYCLES(STEP)) dut (
        .CLK(CLK), .RSTn(RSTn), .En(En), .Mode(Mode), .Speed(Speed),
        .LED_out(LED_out), .Step_Tick(Step_Tick)
    );

    always #5 CLK = ~CLK;

    // Model: mode, position/sequence index within the pattern, elapsed enabled cycles.
    logic [1:0] mm = 2'b00;
    int ms = 0;
    int me = 0;
    int mp = STEP;
    bit mt = 1'b0;

    function automatic logic [N-1:0] leds(input logic [1:0] m, input int s);
        logic [N-1:0] one;
        one = N'(1);
        case (m)
            2'd0, 2'd1: return one << s;
            2'd2:       return one << ((s < N) ? s : (2*N - 2 - s));
            default:    return (s != 0) ? {N{1'b1}} : {N{1'b0}};
        endcase
    endfunction

    function automatic int adv(input logic [1:0] m, input int s);
        case (m)
            2'd0:    return (s + 1) % N;
            2'd1:    return (s + N - 1) % N;
            2'd2:    return (s + 1) % (2*N - 2);
            default: return 1 - s;
        endcase
    endfunction

    initial forever begin
        @(posedge CLK or negedge RSTn);
        if (!RSTn) begin
            mm = 2'b00; ms = 0; me = 0; mp = STEP; mt = 1'b0;
        end else if (Mode != mm) begin
            mm = Mode; ms = (Mode == 2'd1) ? N-1 : 0; me = 0; mt = 1'b0;
        end else if (En) begin
            if (me == 0) mp = STEP >> Speed;
            me++;
            if (me == mp) begin
                me = 0; ms = adv(mm, ms); mt = 1'b1;
            end else begin
                mt = 1'b0;
            end
        end else begin
            mt = 1'b0;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_on) begin
            n_chk++;
            if (LED_out !== leds(mm, ms) || Step_Tick !== mt) begin
                n_fail++;
                $display("FAIL model t=%0t LED_out=%b exp=%b Step_Tick=%b exp=%b",
                         $time, LED_out, leds(mm, ms), Step_Tick, mt);
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] led, input logic tk);
        n_chk++;
        if (LED_out !== led || Step_Tick !== tk) begin
            n_fail++;
            $display("FAIL %s LED_out=%b exp=%b Step_Tick=%b exp=%b",
                     name, LED_out, led, Step_Tick, tk);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        cyc(2);
        chk("reset", 4'b0001, 1'b0);
        RSTn = 1'b1;
        chk_on = 1'b1;
        cyc(7);  chk("rol_pre_step", 4'b0001, 1'b0);
        cyc(1);  chk("rol_step1", 4'b0010, 1'b1);
        cyc(1);  chk("rol_tick_clear", 4'b0010, 1'b0);

        // Mode switch lands on the same edge as cnt==7.
        cyc(6);  Mode = 2'b01;
        cyc(1);  chk("reload_wins", 4'b1000, 1'b0);
        cyc(7);  chk("ror_pre_step", 4'b1000, 1'b0);
        cyc(1);  chk("ror_step", 4'b0100, 1'b1);

        cyc(3);  En = 1'b0;
        cyc(20); chk("freeze_hold", 4'b0100, 1'b0);
        En = 1'b1;
        cyc(4);  chk("freeze_resume_pre", 4'b0100, 1'b0);
        cyc(1);  chk("freeze_resume_step", 4'b0010, 1'b1);

        Mode = 2'b11;
        cyc(1);  chk("blink_init", 4'b0000, 1'b0);
        cyc(8);  chk("blink_on", 4'b1111, 1'b1);
        cyc(8);  chk("blink_off", 4'b0000, 1'b1);

        Mode = 2'b10; Speed = 2'd1;
        cyc(1);  chk("ping_init", 4'b0001, 1'b0);
        cyc(4);  chk("ping_1", 4'b0010, 1'b1);
        cyc(4);  chk("ping_2", 4'b0100, 1'b1);
        cyc(4);  chk("ping_3", 4'b1000, 1'b1);
        cyc(4);  chk("ping_4", 4'b0100, 1'b1);
        cyc(1);  Speed = 2'd3;
        cyc(3);  chk("speed_step_complete", 4'b0010, 1'b1);
        cyc(1);  chk("speed_fast_1", 4'b0001, 1'b1);
        cyc(1);  chk("speed_fast_2", 4'b0010, 1'b1);
        cyc(2);  chk("speed_fast_4", 4'b1000, 1'b1);
        cyc(1);  chk("dir_down", 4'b0100, 1'b1);

        #2 RSTn = 1'b0;
        #1 chk("async_reset", 4'b0001, 1'b0);
        @(negedge CLK); RSTn = 1'b1;
        cyc(1);  chk("reload_after_reset", 4'b0001, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            En = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) Mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) Speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #2 RSTn = 1'b0;
                @(negedge CLK);
                RSTn = 1'b1;
            end
        end
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
